// File: rtl/gate_sched_pkg.sv
// Shared types and constants for the gated-counter burst scheduler.
// Optional statistics output is enabled with the GATE_SCHED_STATS_EN macro.
package gate_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int GAP_W   = 4;
  localparam int STATS_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot picker. The search starts at the pointer; the pointer
// moves past the winner only when the caller strobes update.
module rr_arbiter
  import gate_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] pick
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] pick_idx;
  logic [SUM_W-1:0] idx_w;
  logic             found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx_w    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Walk (ptr + i) mod NUM_REQ without a divider.
      idx_w = {1'b0, ptr} + SUM_W'(i);
      if (idx_w >= SUM_W'(NUM_REQ)) idx_w = idx_w - SUM_W'(NUM_REQ);
      if (!found && req[idx_w[PTR_W-1:0]]) begin
        pick[idx_w[PTR_W-1:0]] = 1'b1;
        pick_idx               = idx_w[PTR_W-1:0];
        found                  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/gate_sched_ctrl.sv
// Round-robin burst scheduler driving the enable of a clock-gated counter,
// with a minimum gate-off gap between bursts. GATE_SCHED_STATS_EN adds gated_cycles.
module gate_sched_ctrl
  import gate_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BURST_W = 4,
  parameter int GAP_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [BURST_W-1:0] burst_len,
  output logic               gate_en,
  output logic [NUM_REQ-1:0] grant,
  output logic               done,
  output logic               busy,
  output state_t             dbg_state
`ifdef GATE_SCHED_STATS_EN
  ,
  output logic [STATS_W-1:0] gated_cycles
`endif
);

  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_CYC);
  localparam logic [BURST_W-1:0] ONE      = BURST_W'(1);

  state_t             state, state_d;
  logic [BURST_W-1:0] remain, remain_d, len_eff;
  logic [GAP_W-1:0]   gap_cnt, gap_d;
  logic [NUM_REQ-1:0] grant_d, pick;
  logic               arb_update, any_req, do_arb;

  assign any_req   = |req;
  assign len_eff   = (burst_len == '0) ? ONE : burst_len;
  assign dbg_state = state;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (arb_update),
    .pick   (pick)
  );

  // remain counts enabled cycles left including the current one.
  always_comb begin
    state_d    = state;
    remain_d   = remain;
    gap_d      = gap_cnt;
    grant_d    = grant;
    arb_update = 1'b0;
    do_arb     = 1'b0;
    case (state)
      ST_IDLE: do_arb = 1'b1;
      ST_RUN: begin
        if (remain == ONE) begin
          if (GAP_CYC > 0) begin
            state_d  = ST_GAP;
            gap_d    = GAP_LOAD;
            grant_d  = '0;
            remain_d = '0;
          end else begin
            do_arb = 1'b1;
          end
        end else begin
          remain_d = remain - ONE;
        end
      end
      ST_GAP: begin
        grant_d = '0;
        if (gap_cnt == GAP_W'(1)) begin
          gap_d  = '0;
          do_arb = 1'b1;
        end else begin
          gap_d = gap_cnt - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_arb) begin
      if (any_req) begin
        state_d    = ST_RUN;
        grant_d    = pick;
        remain_d   = len_eff;
        arb_update = 1'b1;
      end else begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        remain_d = '0;
      end
    end
  end

  // Outputs are computed from next-state values so every port is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      remain  <= '0;
      gap_cnt <= '0;
      grant   <= '0;
      gate_en <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      remain  <= remain_d;
      gap_cnt <= gap_d;
      grant   <= grant_d;
      gate_en <= (state_d == ST_RUN);
      done    <= (state_d == ST_RUN) && (remain_d == ONE);
      busy    <= (state_d != ST_IDLE);
    end
  end

`ifdef GATE_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gated_cycles <= '0;
    end else if (!gate_en && (gated_cycles != '1)) begin
      gated_cycles <= gated_cycles + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_gate_sched_ctrl.sv
// Bench for gate_sched_ctrl: one instance with a 2-cycle gap, one with no gap.
// Burst expectations {grant, length, gap-before} are queued and checked on done.
module tb_gate_sched_ctrl;
  import gate_sched_pkg::*;

  localparam int DC = 31;  // gap-before field value meaning "not checked"

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0, req0 = '0;
  logic [3:0] burst_len = '0, burst_len0 = '0;
  logic       gate_en, done, busy, gate_en0, done0, busy0;
  logic [3:0] grant, grant0;
  state_t     dbg_state, dbg_state0;
`ifdef GATE_SCHED_STATS_EN
  logic [15:0] gated_cycles, gated_cycles0;
`endif

  int total = 0;
  int bad   = 0;
  logic [13:0] exp_q[$];
  logic [13:0] exp0_q[$];

  always #5 clk = ~clk;

  gate_sched_ctrl #(.NUM_REQ(4), .BURST_W(4), .GAP_CYC(2)) dut (
    .clk(clk), .rst(rst), .req(req), .burst_len(burst_len),
    .gate_en(gate_en), .grant(grant), .done(done), .busy(busy),
    .dbg_state(dbg_state)
`ifdef GATE_SCHED_STATS_EN
    , .gated_cycles(gated_cycles)
`endif
  );

  gate_sched_ctrl #(.NUM_REQ(4), .BURST_W(4), .GAP_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .burst_len(burst_len0),
    .gate_en(gate_en0), .grant(grant0), .done(done0), .busy(busy0),
    .dbg_state(dbg_state0)
`ifdef GATE_SCHED_STATS_EN
    , .gated_cycles(gated_cycles0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [13:0] item(input logic [3:0] g, input int len, input int gap);
    return {g, 5'(len), 5'(gap)};
  endfunction

  // Burst monitors: measure each burst's length and preceding gate-off time.
  logic prev_ge = 0, prev_dn = 0;
  logic [3:0] prev_gr = '0;
  int run_len = 0, off_cnt = 0, gap_b = 0;
  logic [13:0] e;
  always @(negedge clk) begin
    if (gate_en) begin
      if (!prev_ge || grant != prev_gr || prev_dn) begin
        gap_b   = prev_ge ? 0 : off_cnt;
        run_len = 1;
      end else run_len++;
      off_cnt = 0;
    end else off_cnt++;
    if (done) begin
      check("done_with_gate", gate_en, 1);
      if (exp_q.size() == 0) check("unexpected_done", {grant, run_len[4:0]}, 0);
      else begin
        e = exp_q.pop_front();
        check("burst_grant", grant, e[13:10]);
        check("burst_len", run_len, e[9:5]);
        if (e[4:0] != 5'(DC)) check("burst_gap", gap_b, e[4:0]);
      end
    end
    prev_ge = gate_en; prev_gr = grant; prev_dn = done;
  end

  logic prev_ge0 = 0, prev_dn0 = 0;
  logic [3:0] prev_gr0 = '0;
  int run_len0 = 0, off_cnt0 = 0, gap_b0 = 0;
  logic [13:0] e0;
  always @(negedge clk) begin
    if (gate_en0) begin
      if (!prev_ge0 || grant0 != prev_gr0 || prev_dn0) begin
        gap_b0   = prev_ge0 ? 0 : off_cnt0;
        run_len0 = 1;
      end else run_len0++;
      off_cnt0 = 0;
    end else off_cnt0++;
    if (done0) begin
      check("z_done_with_gate", gate_en0, 1);
      if (exp0_q.size() == 0) check("z_unexpected_done", {grant0, run_len0[4:0]}, 0);
      else begin
        e0 = exp0_q.pop_front();
        check("z_burst_grant", grant0, e0[13:10]);
        check("z_burst_len", run_len0, e0[9:5]);
        if (e0[4:0] != 5'(DC)) check("z_burst_gap", gap_b0, e0[4:0]);
      end
    end
    prev_ge0 = gate_en0; prev_gr0 = grant0; prev_dn0 = done0;
  end

  task automatic wait_dones(input int n);
    int seen = 0;
    for (int c = 0; c < 200 && seen < n; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("wait_done", seen, n);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 50 && busy; c++) @(negedge clk);
    check("wait_idle", busy, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset held with all requests pending: nothing may come out.
    rst = 1'b1; req = 4'b1111; burst_len = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("rst_outputs", {gate_en, grant, done, busy}, 0);
      check("rst_state", dbg_state, ST_IDLE);
      check("rst_outputs_z", {gate_en0, grant0, done0, busy0}, 0);
`ifdef GATE_SCHED_STATS_EN
      check("rst_stats", gated_cycles, 0);
`endif
    end
    exp_q.push_back(item(4'b0001, 2, DC));
    rst = 1'b0;
    @(negedge clk);
    check("first_grant", grant, 4'b0001);
    check("first_gate_en", {gate_en, busy}, 2'b11);
    wait_dones(1);
    req = '0;
    wait_idle();

    // Single burst followed by the gap and a return to IDLE.
    exp_q.push_back(item(4'b0100, 5, DC));
    req = 4'b0100; burst_len = 4'd5;
    wait_dones(1);
    req = '0;
    @(negedge clk);
    check("gap1_state", dbg_state, ST_GAP);
    check("gap1_outputs", {gate_en, grant, done, busy}, 7'b0000001);
    @(negedge clk);
    check("gap2_state", dbg_state, ST_GAP);
    @(negedge clk);
    check("gap_end_state", dbg_state, ST_IDLE);
    check("gap_end_busy", busy, 0);

    // Round-robin over requesters 0, 1 and 3.
    pulse_reset();
    exp_q.push_back(item(4'b0001, 3, DC));
    exp_q.push_back(item(4'b0010, 3, 2));
    exp_q.push_back(item(4'b1000, 3, 2));
    exp_q.push_back(item(4'b0001, 3, 2));
    req = 4'b1011; burst_len = 4'd3;
    wait_dones(4);
    req = '0;
    wait_idle();
    check("rr_queue_empty", exp_q.size(), 0);

    // Reset in the 4th cycle of an 8-cycle burst aborts it without done.
    pulse_reset();
    req = 4'b0100; burst_len = 4'd8;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("pre_abort", {gate_en, grant, done}, 6'b101000);
    @(negedge clk);
    check("abort_outputs", {gate_en, grant, done, busy}, 0);
    check("abort_state", dbg_state, ST_IDLE);
    exp_q.push_back(item(4'b0001, 1, DC));
    req = 4'b1111; burst_len = 4'd1;
    rst = 1'b0;
    @(negedge clk);
    check("ptr_restart", grant, 4'b0001);
    req = '0;
    wait_idle();

    // No gap, zero length: single-cycle bursts back to back.
    pulse_reset();
    for (int i = 0; i < 6; i++)
      exp0_q.push_back(item((i % 2 == 0) ? 4'b0001 : 4'b0010, 1, (i == 0) ? DC : 0));
    req0 = 4'b0011; burst_len0 = 4'd0;
    repeat (6) @(posedge clk);
    #1 req0 = '0;
    repeat (3) @(negedge clk);
    check("z_queue_empty", exp0_q.size(), 0);
    check("z_idle", {busy0, gate_en0}, 0);

`ifdef GATE_SCHED_STATS_EN
    // 20 idle cycles, a 5-cycle burst, then 2 gap cycles.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (19) @(posedge clk);
    exp_q.push_back(item(4'b0001, 5, DC));
    #1 req = 4'b0001; burst_len = 4'd5;
    repeat (5) @(posedge clk);
    #1 req = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stats_count", gated_cycles, 22);
    check("stats_state", dbg_state, ST_IDLE);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
